// File: rtl/tile_fetch_sequencer_if.sv
// Handshake/bus bundle for tile_fetch_sequencer.
//   master: job control and compute-side release (drives start/config/tile_consumed)
//   slave : the sequencer (drives SRAM read, buffer writes, bank status, busy/done)
interface tile_fetch_sequencer_if #(
  parameter int unsigned SRAM_AW = 16,
  parameter int unsigned BUF_AW  = 6
);
  localparam int unsigned NT_W = 8;

  // job control
  logic               start;
  logic [SRAM_AW-1:0] w_base;
  logic [SRAM_AW-1:0] a_base;
  logic [BUF_AW-1:0]  tile_len_m1;
  logic [NT_W-1:0]    num_tiles;
  logic               busy;
  logic               done;

  // SRAM read port
  logic               sram_en;
  logic [SRAM_AW-1:0] sram_read_address;
  logic               sram_rd_is_w;

  // local buffer write ports
  logic               w_write_en;
  logic [BUF_AW-1:0]  w_write_address;
  logic               a_write_en;
  logic [BUF_AW-1:0]  a_write_address;

  // compute-side bank handshake
  logic               wr_bank;
  logic               rd_bank;
  logic               tile_ready;
  logic               tile_consumed;

  modport master (
    output start, w_base, a_base, tile_len_m1, num_tiles, tile_consumed,
    input  busy, done, sram_en, sram_read_address, sram_rd_is_w,
           w_write_en, w_write_address, a_write_en, a_write_address,
           wr_bank, rd_bank, tile_ready
  );

  modport slave (
    input  start, w_base, a_base, tile_len_m1, num_tiles, tile_consumed,
    output busy, done, sram_en, sram_read_address, sram_rd_is_w,
           w_write_en, w_write_address, a_write_en, a_write_address,
           wr_bank, rd_bank, tile_ready
  );
endinterface

// File: rtl/tile_fetch_sequencer.sv
// Ping-pong tile loader: streams interleaved weight/activation words from the
// shared SRAM read port into a two-bank local buffer and hands full banks to
// compute with a ready/consumed handshake.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - tile_fetch_sequencer_if.slave (job control, SRAM read, buffer
//          writes, bank handshake, busy/done)
module tile_fetch_sequencer #(
  parameter int unsigned SRAM_AW  = 16,
  parameter int unsigned BUF_AW   = 6,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tile_fetch_sequencer_if.slave bus
);
  localparam int unsigned NT_W  = 8;
  localparam int unsigned LAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WAIT_BANK,
    S_FINISH
  } state_t;

  state_t             r_state;
  logic [SRAM_AW-1:0] r_w_ptr;
  logic [SRAM_AW-1:0] r_a_ptr;
  logic [SRAM_AW-1:0] r_rd_addr;
  logic [BUF_AW-1:0]  r_len_m1;
  logic [BUF_AW-1:0]  r_k;
  logic [NT_W-1:0]    r_num_tiles;
  logic [NT_W-1:0]    r_tiles_filled;
  logic [LAT_W-1:0]   r_drain_cnt;
  logic               r_sram_en;
  logic               r_is_w;
  logic               r_busy;
  logic               r_done;

  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic               r_tile_ready;

  logic               r_pw_en [SRAM_LAT];
  logic               r_pa_en [SRAM_LAT];
  logic [BUF_AW-1:0]  r_p_k   [SRAM_LAT];

  logic               w_drain_exit;
  logic               w_consume;
  logic [1:0]         w_set_mask;
  logic [1:0]         w_clr_mask;
  logic [1:0]         w_full_nxt;
  logic               w_rd_bank_nxt;
  logic               w_last_tile;
  logic               w_launch;

  // Bank bookkeeping: fill completion sets full[wr_bank], a valid consume
  // clears full[rd_bank]; the two never target the same bank.
  assign w_drain_exit  = (r_state == S_DRAIN) && (r_drain_cnt == '0);
  assign w_consume     = bus.tile_consumed && r_full[r_rd_bank];
  assign w_set_mask    = {w_drain_exit &  r_wr_bank, w_drain_exit & ~r_wr_bank};
  assign w_clr_mask    = {w_consume    &  r_rd_bank, w_consume    & ~r_rd_bank};
  assign w_full_nxt    = (r_full | w_set_mask) & ~w_clr_mask;
  assign w_rd_bank_nxt = r_rd_bank ^ w_consume;
  assign w_last_tile   = (NT_W'(r_tiles_filled + NT_W'(1)) == r_num_tiles);

  // Start the first W read of a new tile; the bank check uses next-cycle
  // full state so a consume in the same cycle frees the bank immediately.
  assign w_launch = (w_drain_exit && !w_last_tile && !w_full_nxt[!r_wr_bank]) ||
                    ((r_state == S_WAIT_BANK) && !w_full_nxt[r_wr_bank]);

  // Bank full flags, bank pointers and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_tile_ready <= 1'b0;
    end else begin
      r_full       <= w_full_nxt;
      r_wr_bank    <= r_wr_bank ^ w_drain_exit;
      r_rd_bank    <= w_rd_bank_nxt;
      r_tile_ready <= w_full_nxt[w_rd_bank_nxt];
    end
  end

  // Sequencer FSM; the read registers describe the SRAM access in the
  // current cycle, so every transition also sets up the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_w_ptr        <= '0;
      r_a_ptr        <= '0;
      r_rd_addr      <= '0;
      r_len_m1       <= '0;
      r_k            <= '0;
      r_num_tiles    <= '0;
      r_tiles_filled <= '0;
      r_drain_cnt    <= '0;
      r_sram_en      <= 1'b0;
      r_is_w         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len_m1       <= bus.tile_len_m1;
            r_num_tiles    <= bus.num_tiles;
            r_tiles_filled <= '0;
            r_busy         <= 1'b1;
            r_a_ptr        <= bus.a_base;
            r_k            <= '0;
            if (bus.num_tiles == '0) begin
              r_w_ptr <= bus.w_base;
              r_state <= S_FINISH;
            end else begin
              r_sram_en <= 1'b1;
              r_is_w    <= 1'b1;
              r_rd_addr <= bus.w_base;
              r_w_ptr   <= bus.w_base + SRAM_AW'(1);
              r_state   <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (r_is_w) begin
            r_is_w    <= 1'b0;
            r_rd_addr <= r_a_ptr;
            r_a_ptr   <= r_a_ptr + SRAM_AW'(1);
          end else if (r_k == r_len_m1) begin
            r_sram_en   <= 1'b0;
            r_rd_addr   <= '0;
            r_drain_cnt <= LAT_W'(SRAM_LAT - 1);
            r_state     <= S_DRAIN;
          end else begin
            r_k       <= r_k + BUF_AW'(1);
            r_is_w    <= 1'b1;
            r_rd_addr <= r_w_ptr;
            r_w_ptr   <= r_w_ptr + SRAM_AW'(1);
          end
        end

        S_DRAIN: begin
          if (r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - LAT_W'(1);
          end else begin
            r_tiles_filled <= r_tiles_filled + NT_W'(1);
            if (w_last_tile) begin
              r_state <= S_FINISH;
            end else if (!w_launch) begin
              r_state <= S_WAIT_BANK;
            end
          end
        end

        S_WAIT_BANK: begin
        end

        S_FINISH: begin
          if (w_full_nxt == 2'b00) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      if (w_launch) begin
        r_state   <= S_ISSUE;
        r_sram_en <= 1'b1;
        r_is_w    <= 1'b1;
        r_rd_addr <= r_w_ptr;
        r_w_ptr   <= r_w_ptr + SRAM_AW'(1);
        r_k       <= '0;
      end
    end
  end

  // Read-to-write delay line matching the SRAM latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SRAM_LAT; i++) begin
        r_pw_en[i] <= 1'b0;
        r_pa_en[i] <= 1'b0;
        r_p_k[i]   <= '0;
      end
    end else begin
      r_pw_en[0] <= r_sram_en &  r_is_w;
      r_pa_en[0] <= r_sram_en & ~r_is_w;
      r_p_k[0]   <= r_k;
      for (int i = 1; i < SRAM_LAT; i++) begin
        r_pw_en[i] <= r_pw_en[i-1];
        r_pa_en[i] <= r_pa_en[i-1];
        r_p_k[i]   <= r_p_k[i-1];
      end
    end
  end

  assign bus.sram_en           = r_sram_en;
  assign bus.sram_read_address = r_rd_addr;
  assign bus.sram_rd_is_w      = r_is_w;
  assign bus.w_write_en        = r_pw_en[SRAM_LAT-1];
  assign bus.w_write_address   = r_pw_en[SRAM_LAT-1] ? r_p_k[SRAM_LAT-1] : '0;
  assign bus.a_write_en        = r_pa_en[SRAM_LAT-1];
  assign bus.a_write_address   = r_pa_en[SRAM_LAT-1] ? r_p_k[SRAM_LAT-1] : '0;
  assign bus.wr_bank           = r_wr_bank;
  assign bus.rd_bank           = r_rd_bank;
  assign bus.tile_ready        = r_tile_ready;
  assign bus.busy              = r_busy;
  assign bus.done              = r_done;
endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// Directed bench for tile_fetch_sequencer: one instance at SRAM_LAT=1 and one
// at SRAM_LAT=3, driven through their interfaces, sampled on the falling edge.
module tb_tile_fetch_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  tile_fetch_sequencer_if #(.SRAM_AW(16), .BUF_AW(6)) bus1 ();
  tile_fetch_sequencer_if #(.SRAM_AW(16), .BUF_AW(6)) bus3 ();

  tile_fetch_sequencer #(.SRAM_AW(16), .BUF_AW(6), .SRAM_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  tile_fetch_sequencer #(.SRAM_AW(16), .BUF_AW(6), .SRAM_LAT(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic cfg1(input logic [15:0] wb, input logic [15:0] ab,
                      input logic [5:0] len, input logic [7:0] nt);
    bus1.w_base      = wb;
    bus1.a_base      = ab;
    bus1.tile_len_m1 = len;
    bus1.num_tiles   = nt;
  endtask

  initial begin
    int j;
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_errors = 0;
    bus1.start = 1'b0; bus1.tile_consumed = 1'b0;
    cfg1(16'h0, 16'h0, 6'd0, 8'd0);
    bus3.start = 1'b0; bus3.tile_consumed = 1'b0;
    bus3.w_base = 16'h0; bus3.a_base = 16'h0; bus3.tile_len_m1 = 6'd0; bus3.num_tiles = 8'd0;

    // ---- reset state ----
    do_reset();
    chk("rst_busy",       32'(bus1.busy),       32'd0);
    chk("rst_done",       32'(bus1.done),       32'd0);
    chk("rst_sram_en",    32'(bus1.sram_en),    32'd0);
    chk("rst_tile_ready", 32'(bus1.tile_ready), 32'd0);
    chk("rst_wr_bank",    32'(bus1.wr_bank),    32'd0);
    chk("rst_rd_bank",    32'(bus1.rd_bank),    32'd0);

    // ---- single tile, with ignored start and ignored consume mid-tile ----
    cfg1(16'h0100, 16'h0200, 6'd3, 8'd1);
    bus1.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk($sformatf("t1_en_%0d", i),   32'(bus1.sram_en),      32'd1);
      chk($sformatf("t1_isw_%0d", i),  32'(bus1.sram_rd_is_w), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t1_addr_%0d", i), 32'(bus1.sram_read_address),
          (i % 2 == 0) ? 32'h100 + 32'(i / 2) : 32'h200 + 32'(i / 2));
      if (i > 0) begin
        j = i - 1;
        chk($sformatf("t1_wwe_%0d", j), 32'(bus1.w_write_en), (j % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("t1_awe_%0d", j), 32'(bus1.a_write_en), (j % 2 == 1) ? 32'd1 : 32'd0);
        if (j % 2 == 0) chk($sformatf("t1_wwa_%0d", j), 32'(bus1.w_write_address), 32'(j / 2));
        else            chk($sformatf("t1_awa_%0d", j), 32'(bus1.a_write_address), 32'(j / 2));
      end else begin
        chk("t1_no_write_first", 32'(bus1.w_write_en | bus1.a_write_en), 32'd0);
      end
      bus1.start         = (i == 2);
      bus1.tile_consumed = (i == 3);
      if (i == 2) bus1.w_base = 16'h5555;
    end
    tick(1);
    chk("t1_drain_en",   32'(bus1.sram_en),         32'd0);
    chk("t1_last_awe",   32'(bus1.a_write_en),      32'd1);
    chk("t1_last_awa",   32'(bus1.a_write_address), 32'd3);
    chk("t1_last_wwe",   32'(bus1.w_write_en),      32'd0);
    chk("t1_ready_lo",   32'(bus1.tile_ready),      32'd0);
    chk("t1_busy",       32'(bus1.busy),            32'd1);
    tick(1);
    chk("t1_ready_hi",   32'(bus1.tile_ready),      32'd1);
    chk("t1_rd_bank0",   32'(bus1.rd_bank),         32'd0);
    chk("t1_wr_bank1",   32'(bus1.wr_bank),         32'd1);
    chk("t1_no_done",    32'(bus1.done),            32'd0);
    bus1.tile_consumed = 1'b1;
    tick(1);
    bus1.tile_consumed = 1'b0;
    chk("t1_done",       32'(bus1.done),            32'd1);
    chk("t1_busy_lo",    32'(bus1.busy),            32'd0);
    chk("t1_rd_bank1",   32'(bus1.rd_bank),         32'd1);
    chk("t1_ready_clr",  32'(bus1.tile_ready),      32'd0);
    tick(1);
    chk("t1_done_pulse", 32'(bus1.done),            32'd0);

    // ---- zero tiles ----
    do_reset();
    cfg1(16'h0100, 16'h0200, 6'd3, 8'd0);
    bus1.start = 1'b1;
    tick(1);
    bus1.start = 1'b0;
    chk("z_busy",    32'(bus1.busy),    32'd1);
    chk("z_en1",     32'(bus1.sram_en), 32'd0);
    chk("z_done1",   32'(bus1.done),    32'd0);
    tick(1);
    chk("z_done2",   32'(bus1.done),    32'd1);
    chk("z_busy2",   32'(bus1.busy),    32'd0);
    chk("z_en2",     32'(bus1.sram_en | bus1.w_write_en | bus1.a_write_en), 32'd0);
    tick(1);
    chk("z_done3",   32'(bus1.done),    32'd0);

    // ---- ping-pong overlap, three tiles of two words ----
    do_reset();
    cfg1(16'h1000, 16'h2000, 6'd1, 8'd3);
    bus1.start = 1'b1;
    tick(1);
    bus1.start = 1'b0;
    chk("pp_c1_addr",   32'(bus1.sram_read_address), 32'h1000);
    tick(5);
    chk("pp_c6_addr",   32'(bus1.sram_read_address), 32'h1002);
    chk("pp_c6_wrbank", 32'(bus1.wr_bank),           32'd1);
    chk("pp_c6_ready",  32'(bus1.tile_ready),        32'd1);
    tick(1);
    chk("pp_c7_wwe",    32'(bus1.w_write_en),        32'd1);
    chk("pp_c7_wwa",    32'(bus1.w_write_address),   32'd0);
    chk("pp_c7_addr",   32'(bus1.sram_read_address), 32'h2002);
    tick(5);
    chk("pp_wait_en",   32'(bus1.sram_en),           32'd0);
    chk("pp_wait_busy", 32'(bus1.busy),              32'd1);
    chk("pp_wait_wrb",  32'(bus1.wr_bank),           32'd0);
    chk("pp_wait_rdb",  32'(bus1.rd_bank),           32'd0);
    chk("pp_wait_rdy",  32'(bus1.tile_ready),        32'd1);
    bus1.tile_consumed = 1'b1;
    tick(1);
    bus1.tile_consumed = 1'b0;
    chk("pp_t2_en",     32'(bus1.sram_en),           32'd1);
    chk("pp_t2_addr",   32'(bus1.sram_read_address), 32'h1004);
    chk("pp_t2_isw",    32'(bus1.sram_rd_is_w),      32'd1);
    chk("pp_t2_rdb",    32'(bus1.rd_bank),           32'd1);
    chk("pp_t2_wrb",    32'(bus1.wr_bank),           32'd0);
    chk("pp_t2_rdy",    32'(bus1.tile_ready),        32'd1);
    tick(5);
    chk("pp_fin_rdy",   32'(bus1.tile_ready),        32'd1);
    chk("pp_fin_rdb",   32'(bus1.rd_bank),           32'd1);
    chk("pp_fin_busy",  32'(bus1.busy),              32'd1);
    bus1.tile_consumed = 1'b1;
    tick(1);
    chk("pp_c19_rdb",   32'(bus1.rd_bank),           32'd0);
    chk("pp_c19_rdy",   32'(bus1.tile_ready),        32'd1);
    chk("pp_c19_done",  32'(bus1.done),              32'd0);
    tick(1);
    bus1.tile_consumed = 1'b0;
    chk("pp_done",      32'(bus1.done),              32'd1);
    chk("pp_busy_lo",   32'(bus1.busy),              32'd0);

    // ---- address wrap, then reset mid-ISSUE ----
    do_reset();
    cfg1(16'hFFFE, 16'h0010, 6'd3, 8'd1);
    bus1.start = 1'b1;
    tick(1);
    bus1.start = 1'b0;
    chk("wrap_0", 32'(bus1.sram_read_address), 32'hFFFE);
    tick(2);
    chk("wrap_1", 32'(bus1.sram_read_address), 32'hFFFF);
    tick(2);
    chk("wrap_2", 32'(bus1.sram_read_address), 32'h0000);
    tick(2);
    chk("wrap_3", 32'(bus1.sram_read_address), 32'h0001);
    rst = 1'b1;
    #1;
    chk("mrst_en",    32'(bus1.sram_en),    32'd0);
    chk("mrst_addr",  32'(bus1.sram_read_address), 32'd0);
    chk("mrst_busy",  32'(bus1.busy),       32'd0);
    chk("mrst_wr",    32'(bus1.w_write_en | bus1.a_write_en), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("mrst_nodone1", 32'(bus1.done), 32'd0);
    tick(1);
    chk("mrst_nodone2", 32'(bus1.done), 32'd0);
    cfg1(16'h0040, 16'h0050, 6'd0, 8'd1);
    bus1.start = 1'b1;
    tick(1);
    bus1.start = 1'b0;
    chk("re_addr",   32'(bus1.sram_read_address), 32'h0040);
    tick(1);
    chk("re_addr_a", 32'(bus1.sram_read_address), 32'h0050);
    tick(2);
    chk("re_ready",  32'(bus1.tile_ready), 32'd1);
    bus1.tile_consumed = 1'b1;
    tick(1);
    bus1.tile_consumed = 1'b0;
    chk("re_done",   32'(bus1.done), 32'd1);

    // ---- SRAM_LAT=3, full 64-word tile ----
    do_reset();
    bus3.w_base = 16'h3000; bus3.a_base = 16'h4000;
    bus3.tile_len_m1 = 6'd63; bus3.num_tiles = 8'd1;
    bus3.start = 1'b1;
    tick(1);
    bus3.start = 1'b0;
    chk("l3_c1_addr", 32'(bus3.sram_read_address), 32'h3000);
    tick(2);
    chk("l3_c3_wwe",  32'(bus3.w_write_en), 32'd0);
    tick(1);
    chk("l3_c4_wwe",  32'(bus3.w_write_en), 32'd1);
    chk("l3_c4_wwa",  32'(bus3.w_write_address), 32'd0);
    chk("l3_c4_awe",  32'(bus3.a_write_en), 32'd0);
    tick(124);
    chk("l3_last_en",   32'(bus3.sram_en), 32'd1);
    chk("l3_last_addr", 32'(bus3.sram_read_address), 32'h403F);
    chk("l3_last_isw",  32'(bus3.sram_rd_is_w), 32'd0);
    tick(1);
    chk("l3_drain_en",  32'(bus3.sram_en), 32'd0);
    tick(2);
    chk("l3_c131_awe",  32'(bus3.a_write_en), 32'd1);
    chk("l3_c131_awa",  32'(bus3.a_write_address), 32'd63);
    chk("l3_c131_rdy",  32'(bus3.tile_ready), 32'd0);
    tick(1);
    chk("l3_c132_rdy",  32'(bus3.tile_ready), 32'd1);
    chk("l3_c132_awe",  32'(bus3.a_write_en), 32'd0);
    bus3.tile_consumed = 1'b1;
    tick(1);
    bus3.tile_consumed = 1'b0;
    chk("l3_done",      32'(bus3.done), 32'd1);
    chk("l1_idle",      32'(bus1.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
